canny_hold_array: RTL and testbench

- Parametrised successor of the Canny-stage row hold register.
- Captures one word per row (ROWS rows, PIXPERWORD pixels of PIXW bits each) from the shift-buffer stage and presents it, address-tagged, to the gradient/NMS stage.
- Capture pacing comes from an internal beat/pause scheduler.
- Adds valid/ready handshaking, backpressure, abort, and an end-of-frame indication.

---
 rtl/canny_pkg.sv | 28 ++
 rtl/canny_beat_sched.sv | 147 ++++++++++++++
 rtl/canny_hold_array.sv | 128 ++++++++++++
 tb/tb_canny_hold_array.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared types and helpers for the Canny-stage row hold array.
package canny_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  // Wide enough to compare any supported ADDRW without overflow.
  localparam int CMPW = 64;

  function automatic int wordw(input int pixw, input int pixperword);
    return pixw * pixperword;
  endfunction

  function automatic int busw(input int rows, input int pixw, input int pixperword);
    return rows * wordw(pixw, pixperword);
  endfunction

  function automatic logic addr_is_last(input logic [CMPW-1:0] addr,
                                        input logic [CMPW-1:0] step,
                                        input logic [CMPW-1:0] end_addr);
    return (addr + step) > end_addr;
  endfunction

endpackage

// File: rtl/canny_beat_sched.sv
// Beat/pause scheduler: owns frame state, address, burst and pause counters.
// With CANNY_HOLD_BORDER_ZERO_EN it also tracks the image column of addr.
module canny_beat_sched
  import canny_pkg::*;
#(
  parameter int ADDRW      = 24,
  parameter int START_ADDR = 770,
  parameter int END_ADDR   = 2097152,
  parameter int COUNTSTEP  = 2,
  parameter int BEATS      = 3,
  parameter int PAUSE      = 1
`ifdef CANNY_HOLD_BORDER_ZERO_EN
  ,
  parameter int LINEW      = 384
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold_en,
  input  logic                     in_valid,
  input  logic                     out_free,
  output logic                     in_ready,
  output logic                     accept,
  output logic [ADDRW-1:0]         addr,
`ifdef CANNY_HOLD_BORDER_ZERO_EN
  output logic [$clog2(LINEW)-1:0] col,
`endif
  output logic                     frame_done,
  output logic                     busy
);

  localparam int BEATW  = $clog2(BEATS + 1);
  localparam int PAUSEW = (PAUSE > 0) ? $clog2(PAUSE + 1) : 1;
  localparam logic [ADDRW-1:0]  START_L     = ADDRW'(START_ADDR);
  localparam logic [ADDRW-1:0]  STEP_L      = ADDRW'(COUNTSTEP);
  localparam logic [BEATW-1:0]  LAST_BEAT   = BEATW'(BEATS - 1);
  localparam logic [PAUSEW-1:0] LAST_PAUSE  = PAUSEW'(PAUSE - 1);

  state_e            state_q, state_d;
  logic [ADDRW-1:0]  addr_q, addr_d;
  logic [BEATW-1:0]  beat_q, beat_d;
  logic [PAUSEW-1:0] pause_q, pause_d;
  logic              frame_done_q, frame_done_d;
  logic              last;
  logic              go_idle;

`ifdef CANNY_HOLD_BORDER_ZERO_EN
  localparam int COLW = $clog2(LINEW);
  localparam logic [COLW-1:0] COL_START = COLW'(START_ADDR % LINEW);
  localparam logic [COLW:0]   COL_STEP  = (COLW+1)'(COUNTSTEP % LINEW);
  localparam logic [COLW:0]   LINE_L    = (COLW+1)'(LINEW);

  logic [COLW-1:0] col_q, col_d;
  logic [COLW:0]   col_sum;
`endif

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    in_ready     = (state_q == ST_RUN) && out_free;
    accept       = in_ready && in_valid;
    last         = addr_is_last(CMPW'(addr_q), CMPW'(COUNTSTEP), CMPW'(END_ADDR));
    go_idle      = 1'b0;
    state_d      = state_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    pause_d      = pause_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: if (hold_en) state_d = ST_RUN;
      ST_RUN: begin
        if (!hold_en) begin
          go_idle = 1'b1;
        end else if (accept) begin
          addr_d = addr_q + STEP_L;
          if (last) begin
            // The final word ends the frame even when it also closes a burst.
            state_d      = ST_DONE;
            beat_d       = '0;
            frame_done_d = 1'b1;
          end else if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (PAUSE > 0) begin
              state_d = ST_PAUSE;
              pause_d = '0;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (!hold_en)                  go_idle = 1'b1;
        else if (pause_q == LAST_PAUSE) state_d = ST_RUN;
        else                           pause_d = pause_q + 1'b1;
      end
      ST_DONE: if (!hold_en) go_idle = 1'b1;
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d = ST_IDLE;
      addr_d  = START_L;
      beat_d  = '0;
      pause_d = '0;
    end
  end

`ifdef CANNY_HOLD_BORDER_ZERO_EN
  always_comb begin
    col_sum = {1'b0, col_q} + COL_STEP;
    if (col_sum >= LINE_L) col_sum = col_sum - LINE_L;
    col_d = col_q;
    if (go_idle)     col_d = COL_START;
    else if (accept) col_d = col_sum[COLW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) col_q <= COL_START;
    else        col_q <= col_d;
  end

  assign col = col_q;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= START_L;
      beat_q       <= '0;
      pause_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      pause_q      <= pause_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign addr       = addr_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule

// File: rtl/canny_hold_array.sv
// Row hold array: captures one word per row and presents it address-tagged downstream.
// Optional border zeroing of first/last image columns: define CANNY_HOLD_BORDER_ZERO_EN.
module canny_hold_array
  import canny_pkg::*;
#(
  parameter int ROWS       = 3,
  parameter int PIXW       = 8,
  parameter int PIXPERWORD = 3,
  parameter int ADDRW      = 24,
  parameter int START_ADDR = 770,
  parameter int END_ADDR   = 2097152,
  parameter int COUNTSTEP  = 2,
  parameter int BEATS      = 3,
  parameter int PAUSE      = 1,
  parameter int LINEW      = 384
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             hold_en,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ROWS*PIXW*PIXPERWORD-1:0]  in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ROWS*PIXW*PIXPERWORD-1:0]  out_data,
  output logic [ADDRW-1:0]                 out_addr,
  output logic                             frame_done,
  output logic                             busy
);

  localparam int WORDW = wordw(PIXW, PIXPERWORD);
  localparam int BUSW  = busw(ROWS, PIXW, PIXPERWORD);

  if (BEATS < 1 || COUNTSTEP < 1 || LINEW < PIXPERWORD) begin : g_param_check
    $error("canny_hold_array: need BEATS>=1, COUNTSTEP>=1, LINEW>=PIXPERWORD");
  end

  logic             out_valid_q, out_valid_d;
  logic [BUSW-1:0]  out_data_q, out_data_d;
  logic [ADDRW-1:0] out_addr_q, out_addr_d;
  logic [BUSW-1:0]  masked_data;
  logic [ADDRW-1:0] sched_addr;
  logic             accept;

`ifdef CANNY_HOLD_BORDER_ZERO_EN
  localparam int COLW = $clog2(LINEW);
  localparam logic [COLW:0] LINE_L   = (COLW+1)'(LINEW);
  localparam logic [COLW:0] LAST_COL = (COLW+1)'(LINEW - 1);

  logic [COLW-1:0] col;
  logic [COLW:0]   col_k;
`endif

  canny_beat_sched #(
    .ADDRW      (ADDRW),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR),
    .COUNTSTEP  (COUNTSTEP),
    .BEATS      (BEATS),
    .PAUSE      (PAUSE)
`ifdef CANNY_HOLD_BORDER_ZERO_EN
    ,
    .LINEW      (LINEW)
`endif
  ) u_sched (
    .clk        (clk),
    .reset      (reset),
    .hold_en    (hold_en),
    .in_valid   (in_valid),
    .out_free   (!out_valid_q || out_ready),
    .in_ready   (in_ready),
    .accept     (accept),
    .addr       (sched_addr),
`ifdef CANNY_HOLD_BORDER_ZERO_EN
    .col        (col),
`endif
    .frame_done (frame_done),
    .busy       (busy)
  );

`ifdef CANNY_HOLD_BORDER_ZERO_EN
  // Pixel k sits at column col+k, which wraps at most once since LINEW >= PIXPERWORD.
  always_comb begin
    masked_data = in_data;
    col_k       = '0;
    for (int k = 0; k < PIXPERWORD; k++) begin
      col_k = {1'b0, col} + (COLW+1)'(k);
      if (col_k >= LINE_L) col_k = col_k - LINE_L;
      if (col_k == '0 || col_k == LAST_COL) begin
        for (int r = 0; r < ROWS; r++) masked_data[r*WORDW + k*PIXW +: PIXW] = '0;
      end
    end
  end
`else
  assign masked_data = in_data;
`endif

  // A new accept wins over a drain in the same cycle, so the register never empties then.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = masked_data;
      out_addr_d  = sched_addr;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_canny_hold_array.sv
// Self-checking bench for canny_hold_array: directed table, corner sequences, random vs model.
module tb_canny_hold_array;

  localparam int ROWS = 3, PIXW = 8, PPW = 3, ADDRW = 24;
  localparam int START = 10, ENDA = 20, STEP = 2, BEATS = 3, PAUSE = 1, LINEW = 12;
  localparam int WORDW = PIXW * PPW;
  localparam int BUSW  = ROWS * WORDW;

  logic             clk = 1'b0;
  logic             reset, hold_en, in_valid, out_ready;
  logic             in_ready, out_valid, frame_done, busy;
  logic [BUSW-1:0]  in_data, out_data;
  logic [ADDRW-1:0] out_addr;

  always #5 clk = ~clk;

  canny_hold_array #(
    .ROWS(ROWS), .PIXW(PIXW), .PIXPERWORD(PPW), .ADDRW(ADDRW),
    .START_ADDR(START), .END_ADDR(ENDA), .COUNTSTEP(STEP),
    .BEATS(BEATS), .PAUSE(PAUSE), .LINEW(LINEW)
  ) dut (
    .clk(clk), .reset(reset), .hold_en(hold_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .frame_done(frame_done), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected data for a word captured at pixel address addr.
  function automatic logic [BUSW-1:0] border_mask(input logic [BUSW-1:0] d, input int addr);
    logic [BUSW-1:0] r;
    r = d;
`ifdef CANNY_HOLD_BORDER_ZERO_EN
    for (int k = 0; k < PPW; k++) begin
      if ((addr + k) % LINEW == 0 || (addr + k) % LINEW == LINEW - 1)
        for (int row = 0; row < ROWS; row++) r[row*WORDW + k*PIXW +: PIXW] = '0;
    end
`endif
    return r;
  endfunction

  task automatic rand_data();
    logic [95:0] rnd;
    rnd = {$urandom, $urandom, $urandom};
    in_data = rnd[BUSW-1:0];
  endtask

  typedef struct {
    logic he, iv, ordy;
    logic e_ir, e_ov;
    int   e_oa;
    logic e_fd, e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic he, iv, ordy, e_ir, e_ov, input int e_oa, input logic e_fd, e_busy);
    vec_t v;
    v = '{he, iv, ordy, e_ir, e_ov, e_oa, e_fd, e_busy};
    tbl.push_back(v);
  endtask

  // Behavioural model state: frame phase 0=idle, 1=framing, 2=finished.
  int              m_phase, m_addr, m_cnt, m_stall, m_oa;
  logic            m_ov, m_fd;
  logic [BUSW-1:0] m_od;

  task automatic model_reset();
    m_phase = 0; m_addr = START; m_cnt = 0; m_stall = 0;
    m_ov = 0; m_oa = 0; m_od = '0; m_fd = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BUSW-1:0] t_data;
    logic            found;

    reset = 1'b0; hold_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;

    // he iv or | in_ready out_valid out_addr frame_done busy
    add(1,1,1, 0,0, 0,0,0);  add(1,1,1, 1,0, 0,0,1);  add(1,1,1, 1,1,10,0,1);
    add(1,1,1, 1,1,12,0,1);  add(1,1,1, 0,1,14,0,1);  add(1,1,1, 1,0,14,0,1);
    add(1,1,1, 1,1,16,0,1);  add(1,1,1, 1,1,18,0,1);  add(1,1,1, 0,1,20,1,0);
    add(1,1,1, 0,0,20,0,0);  add(1,1,1, 0,0,20,0,0);  add(0,1,1, 0,0,20,0,0);
    add(0,1,1, 0,0,20,0,0);
    // backpressure after first accept, then drain+accept at 12 and 14
    add(1,1,1, 0,0,20,0,0);  add(1,1,1, 1,0,20,0,1);  add(1,1,0, 0,1,10,0,1);
    add(1,1,0, 0,1,10,0,1);  add(1,1,1, 1,1,10,0,1);  add(1,1,1, 1,1,12,0,1);
    add(1,1,1, 0,1,14,0,1);
    // abort with accept, then re-enable restarts at 10
    add(0,1,1, 1,0,14,0,1);  add(0,1,1, 0,1,16,0,0);  add(1,1,1, 0,0,16,0,0);
    add(1,1,1, 1,0,16,0,1);  add(1,0,1, 1,1,10,0,1);  add(1,1,1, 1,0,10,0,1);
    // abort right after accepting 12
    add(0,0,1, 1,1,12,0,1);  add(1,1,1, 0,0,12,0,0);  add(1,1,1, 1,0,12,0,1);
    add(0,0,1, 1,1,10,0,1);  add(0,0,0, 0,0,10,0,0);

    t_data = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      hold_en = tbl[i].he; in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
      rand_data();
      #1;
      check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("tbl%0d_out_addr", i), out_addr, 128'(tbl[i].e_oa));
      check($sformatf("tbl%0d_frame_done", i), frame_done, tbl[i].e_fd);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_ov)
        check($sformatf("tbl%0d_out_data", i), out_data, border_mask(t_data, tbl[i].e_oa));
      if (tbl[i].e_ir && tbl[i].iv) t_data = in_data;
    end

    // Reset while a word is held in RUN discards it.
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      hold_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      rand_data();
      #1;
      found = out_valid && busy;
    end
    check("midrst_reach_valid", found, 1);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_addr", out_addr, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);

    // Randomized run against the behavioural model.
    @(negedge clk);
    reset = 1'b0; hold_en = 1'b0; in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    for (int c = 0; c < 4000; c++) begin
      logic exp_ir, acc;
      @(negedge clk);
      reset     = ($urandom_range(0, 199) != 0);
      hold_en   = ($urandom_range(0, 99) < 96);
      in_valid  = ($urandom_range(0, 99) < 75);
      out_ready = ($urandom_range(0, 99) < 70);
      rand_data();
      #1;
      exp_ir = (m_phase == 1) && (m_stall == 0) && (!m_ov || out_ready);
      check("rnd_in_ready", in_ready, exp_ir);
      check("rnd_out_valid", out_valid, m_ov);
      check("rnd_busy", busy, m_phase == 1);
      check("rnd_frame_done", frame_done, m_fd);
      if (m_ov) begin
        check("rnd_out_addr", out_addr, 128'(m_oa));
        check("rnd_out_data", out_data, m_od);
      end
      acc = exp_ir && in_valid;
      if (!reset) begin
        model_reset();
      end else begin
        if (acc) begin
          m_ov = 1; m_oa = m_addr; m_od = border_mask(in_data, m_addr);
        end else if (out_ready) begin
          m_ov = 0;
        end
        m_fd = 0;
        case (m_phase)
          0: if (hold_en) m_phase = 1;
          1: begin
            if (!hold_en) begin
              m_phase = 0; m_addr = START; m_cnt = 0; m_stall = 0;
            end else if (m_stall > 0) begin
              m_stall--;
            end else if (acc) begin
              if (m_addr + STEP > ENDA) begin
                m_phase = 2; m_fd = 1; m_cnt = 0;
              end else begin
                m_cnt++;
                if (m_cnt == BEATS) begin
                  m_cnt = 0; m_stall = PAUSE;
                end
              end
              m_addr += STEP;
            end
          end
          default: if (!hold_en) begin
            m_phase = 0; m_addr = START; m_cnt = 0;
          end
        endcase
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
